lap_chronometer: RTL and testbench

//  Parametrised stopwatch with start/stop/pause control, selectable time unit and wrap-or-saturate

---
 rtl/lap_chronometer_pkg.sv | 23 ++
 rtl/lap_chronometer_lap_fifo.sv | 85 ++++++++
 rtl/lap_chronometer.sv | 152 +++++++++++++++
 tb/tb_lap_chronometer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_chronometer_pkg.sv
// Shared definitions for the lap chronometer: state encodings, unit
// frequencies, unit-select codes and the prescaler divide helper.
package lap_chronometer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int UNIT_FREQ_MS = 1000;
    localparam int UNIT_FREQ_US = 1000000;

    localparam int UNIT_SEL_MS = 0;
    localparam int UNIT_SEL_US = 1;

    // Number of input clocks per time unit.
    function automatic int unit_div(input int freq_in, input int select_units);
        return freq_in / ((select_units == UNIT_SEL_US) ? UNIT_FREQ_US : UNIT_FREQ_MS);
    endfunction

endpackage

// File: rtl/lap_chronometer_lap_fifo.sv
// Synchronous lap-snapshot FIFO. Power-of-two depth so the pointers wrap
// naturally. The head word is read straight from the storage registers, so a
// push is visible on dout/valid one cycle after the push edge.
module lap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

    // A pop frees a slot on the same edge, so push into a full FIFO is legal
    // when it coincides with a pop.
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
            if (push_ok) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lap_chronometer.sv
// Stopwatch top level: run/pause FSM, unit prescaler, elapsed-unit
// accumulator with wrap or saturate, sticky flags and the lap FIFO.
//
// Lap readout handshake: lapValid means lapData holds the oldest snapshot;
// a cycle with lapRead && lapValid consumes it and the next entry (if any)
// appears on the following cycle. lapRead while !lapValid has no effect.
module lap_chronometer
    import lap_chronometer_pkg::*;
#(
    parameter int FREQ_IN            = 12000000,
    parameter int SELECT_UNITS       = 1,
    parameter int LIMIT_RECORD_TIMER = 1000,
    parameter int WRAP_MODE          = 0,
    parameter int LAP_DEPTH          = 4,
    parameter int SIZE_RECORD_TIMER  = $clog2(LIMIT_RECORD_TIMER),
    parameter int PRESC_W            = $clog2(unit_div(FREQ_IN, SELECT_UNITS))
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clear,
    input  logic                           lapCapture,
    input  logic                           lapRead,
    output logic [SIZE_RECORD_TIMER-1:0]   recordTimer,
    output logic                           running,
    output logic                           overflow,
    output logic [SIZE_RECORD_TIMER-1:0]   lapData,
    output logic                           lapValid,
    output logic [$clog2(LAP_DEPTH):0]     lapCount,
    output logic                           lapOverrun,
    output state_t                         state_dbg,
    output logic [PRESC_W-1:0]             prescale_dbg
);

    localparam int DIV = unit_div(FREQ_IN, SELECT_UNITS);
    localparam logic [PRESC_W-1:0]           PMAX = PRESC_W'(DIV - 1);
    localparam logic [SIZE_RECORD_TIMER-1:0] TMAX = SIZE_RECORD_TIMER'(LIMIT_RECORD_TIMER - 1);

    state_t                         state_q, state_d;
    logic [PRESC_W-1:0]             presc_q, presc_d;
    logic [SIZE_RECORD_TIMER-1:0]   timer_q, timer_d;
    logic                           ovf_q, ovf_d;
    logic                           ovr_q, ovr_d;

    logic cap_ok;
    logic fifo_pop;
    logic fifo_push;
    logic fifo_full;

    // Captures are accepted once the watch has been started; clear wins.
    assign cap_ok    = lapCapture && (state_q != ST_IDLE) && !clear;
    assign fifo_pop  = lapRead && lapValid && !clear;
    assign fifo_push = cap_ok && (!fifo_full || fifo_pop);

    // FSM next state, prescaler/accumulator update and sticky flags.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        timer_d = timer_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;
        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            timer_d = '0;
            ovf_d   = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (cap_ok && fifo_full && !fifo_pop) begin
                ovr_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The stop edge itself does not advance the prescaler, so
                    // the partial unit is preserved exactly across a pause.
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (presc_q == PMAX) begin
                        presc_d = '0;
                        if (timer_q == TMAX) begin
                            ovf_d = 1'b1;
                            if (WRAP_MODE != 0) begin
                                timer_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control and counting registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    lap_fifo #(
        .WIDTH (SIZE_RECORD_TIMER),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (timer_q),
        .dout  (lapData),
        .valid (lapValid),
        .count (lapCount),
        .full  (fifo_full)
    );

    assign recordTimer  = timer_q;
    assign running      = (state_q == ST_RUN);
    assign overflow     = ovf_q;
    assign lapOverrun   = ovr_q;
    assign state_dbg    = state_q;
    assign prescale_dbg = presc_q;

endmodule

// File: tb/tb_lap_chronometer.sv
// Bench for lap_chronometer: a saturating and a wrapping instance share the
// same stimulus; a behavioural model derives expected outputs from elapsed
// running cycles and a simple lap list, and a negedge monitor compares.
module tb_lap_chronometer;

    localparam int FREQ  = 12000;
    localparam int DIV   = 12;
    localparam int LIMIT = 10;
    localparam int DEPTH = 4;
    localparam int VW    = 21;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, lapCapture = 1'b0, lapRead = 1'b0;

    logic [3:0] rt0, rt1, ld0, ld1, pr0, pr1;
    logic       run0, run1, ovf0, ovf1, lv0, lv1, lo0, lo1;
    logic [2:0] lc0, lc1;
    logic [1:0] st0, st1;

    int checks = 0;
    int errors = 0;

    logic [2*VW-1:0] exp_q[$];

    // model state, index 0 = saturating, 1 = wrapping
    int m_st [2];
    int m_runc [2];
    int m_ovf [2];
    int m_ovr [2];
    int lap_mem [2][DEPTH];
    int lap_n [2];

    lap_chronometer #(
        .FREQ_IN(FREQ), .SELECT_UNITS(0), .LIMIT_RECORD_TIMER(LIMIT),
        .WRAP_MODE(0), .LAP_DEPTH(DEPTH)
    ) dut_sat (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .clear(clear),
        .lapCapture(lapCapture), .lapRead(lapRead),
        .recordTimer(rt0), .running(run0), .overflow(ovf0), .lapData(ld0),
        .lapValid(lv0), .lapCount(lc0), .lapOverrun(lo0),
        .state_dbg(st0), .prescale_dbg(pr0)
    );

    lap_chronometer #(
        .FREQ_IN(FREQ), .SELECT_UNITS(0), .LIMIT_RECORD_TIMER(LIMIT),
        .WRAP_MODE(1), .LAP_DEPTH(DEPTH)
    ) dut_wrap (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .clear(clear),
        .lapCapture(lapCapture), .lapRead(lapRead),
        .recordTimer(rt1), .running(run1), .overflow(ovf1), .lapData(ld1),
        .lapValid(lv1), .lapCount(lc1), .lapOverrun(lo1),
        .state_dbg(st1), .prescale_dbg(pr1)
    );

    // clock
    always #5 clk = ~clk;

    function automatic int exp_timer(input int m);
        int u;
        u = m_runc[m] / DIV;
        if (m == 1) return u % LIMIT;
        return (u > LIMIT - 1) ? LIMIT - 1 : u;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int m);
        logic [VW-1:0] v;
        v = {2'(m_st[m]), 4'(m_runc[m] % DIV), 4'(exp_timer(m)),
             (m_st[m] == S_RUN), 1'(m_ovf[m]),
             (lap_n[m] > 0) ? 4'(lap_mem[m][0]) : 4'd0,
             (lap_n[m] > 0), 3'(lap_n[m]), 1'(m_ovr[m])};
        return v;
    endfunction

    function automatic logic [VW-1:0] dut_vec(input int m);
        if (m == 0)
            return {st0, pr0, rt0, run0, ovf0, lv0 ? ld0 : 4'd0, lv0, lc0, lo0};
        return {st1, pr1, rt1, run1, ovf1, lv1 ? ld1 : 4'd0, lv1, lc1, lo1};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = S_IDLE; m_runc[m] = 0; m_ovf[m] = 0; m_ovr[m] = 0; lap_n[m] = 0;
        end
    endtask

    // One clock edge of the reference behaviour for both instances.
    task automatic model_step(input bit r, input bit s, input bit p, input bit c,
                              input bit cap, input bit rd);
        if (r) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            if (c) begin
                m_st[m] = S_IDLE; m_runc[m] = 0; m_ovf[m] = 0; m_ovr[m] = 0; lap_n[m] = 0;
            end else begin
                int pre_t;
                pre_t = exp_timer(m);
                if (rd && lap_n[m] > 0) begin
                    for (int k = 0; k < DEPTH - 1; k++) lap_mem[m][k] = lap_mem[m][k+1];
                    lap_n[m]--;
                end
                if (cap && m_st[m] != S_IDLE) begin
                    if (lap_n[m] < DEPTH) begin
                        lap_mem[m][lap_n[m]] = pre_t;
                        lap_n[m]++;
                    end else begin
                        m_ovr[m] = 1;
                    end
                end
                case (m_st[m])
                    S_IDLE:   if (s) m_st[m] = S_RUN;
                    S_PAUSED: if (s) m_st[m] = S_RUN;
                    S_RUN: begin
                        if (p) m_st[m] = S_PAUSED;
                        else begin
                            m_runc[m]++;
                            if (m_runc[m] / DIV >= LIMIT) begin
                                m_ovf[m] = 1;
                                if (m == 0) m_st[m] = S_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // driver: apply strobes for one cycle, model the edge, queue the expectation
    task automatic step(input bit s, input bit p, input bit c, input bit cap, input bit rd);
        start = s; stop = p; clear = c; lapCapture = cap; lapRead = rd;
        @(posedge clk);
        model_step(rst, s, p, c, cap, rd);
        exp_q.push_back({exp_vec(1), exp_vec(0)});
        #1;
        start = 0; stop = 0; clear = 0; lapCapture = 0; lapRead = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2*VW-1:0] e;
            e = exp_q.pop_front();
            for (int m = 0; m < 2; m++) begin
                logic [VW-1:0] a, x;
                a = dut_vec(m);
                x = (m == 0) ? e[VW-1:0] : e[2*VW-1:VW];
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL cycle_dut%0d t=%0t got %h want %h", m, $time, a, x);
                end
            end
        end
    end

    initial begin
        model_reset();
        idle(3);
        rst = 0;

        // first unit latency and accumulation
        step(1, 0, 0, 0, 0);
        idle(37);
        chk("t1_timer", rt0, 3);
        chk("t1_presc", pr0, 1);

        // pause keeps the partial unit
        idle(4);
        step(0, 1, 0, 0, 0);
        chk("t2_running_paused", run0, 0);
        chk("t2_presc_held", pr0, 5);
        idle(100);
        step(1, 0, 0, 0, 0);
        idle(6);
        chk("t2_before_tick", rt0, 3);
        idle(1);
        chk("t2_tick", rt0, 4);

        // saturate vs wrap
        idle(130);
        chk("t3_sat_timer", rt0, 9);
        chk("t3_sat_ovf", ovf0, 1);
        chk("t3_sat_state", st0, S_DONE);
        chk("t3_wrap_ovf", ovf1, 1);
        chk("t3_wrap_running", run1, 1);
        step(1, 0, 0, 0, 0);
        chk("t3_start_ignored", st0, S_DONE);
        step(0, 0, 1, 0, 0);
        chk("t3_clear_state", st0, S_IDLE);
        chk("t3_clear_timer", rt0, 0);
        chk("t3_clear_ovf", ovf0, 0);

        // lap overrun and readout order
        step(1, 0, 0, 0, 0);
        idle(12);
        for (int u = 1; u <= 5; u++) begin
            step(0, 0, 0, 1, 0);
            idle(11);
        end
        chk("t4_count", lc0, 4);
        chk("t4_overrun", lo0, 1);
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_read", ld0, i);
            step(0, 0, 0, 0, 1);
        end
        chk("t4_empty", lv0, 0);
        step(0, 0, 0, 0, 1);

        // full FIFO with simultaneous push/pop; capture on a tick edge
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            idle(11);
        end
        chk("t5_full", lc0, 4);
        step(0, 0, 0, 1, 1);
        chk("t5_count_kept", lc0, 4);
        chk("t5_no_overrun", lo0, 0);
        chk("t5_head_adv", ld0, 1);
        for (int k = 0; k < DIV && (m_runc[0] % DIV) != DIV - 1; k++) idle(1);
        step(0, 0, 0, 1, 1);
        chk("t5_tick_timer", rt0, 5);
        step(0, 1, 0, 0, 0);
        chk("t5_r0", ld0, 2); step(0, 0, 0, 0, 1);
        chk("t5_r1", ld0, 3); step(0, 0, 0, 0, 1);
        chk("t5_r2", ld0, 4); step(0, 0, 0, 0, 1);
        chk("t5_tick_old", ld0, 4); step(0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0);
        end

        // asynchronous reset between edges
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(20);
        step(0, 0, 0, 1, 0);
        #2 rst = 1;
        #1;
        chk("t6_async_sat", int'(dut_vec(0)), 0);
        chk("t6_async_wrap", int'(dut_vec(1)), 0);
        exp_q.delete();
        model_reset();
        idle(2);
        rst = 0;
        step(1, 0, 0, 0, 0);
        idle(5);
        step(1, 1, 1, 0, 0);
        chk("t6_all_state", st0, S_IDLE);
        chk("t6_all_timer", rt0, 0);
        idle(2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
